// File: rtl/cyclic_queue_fifo_pkg.sv
// Shared definitions for the cyclic queue FIFO: operation encoding and
// width/sanity helpers reused by every queue instance in the datapath.
package cyclic_queue_fifo_pkg;

   // Per-cycle operation, {read_accept, write_accept}
   typedef enum logic [1:0] {
      CQ_IDLE = 2'b00,
      CQ_WR   = 2'b01,
      CQ_RD   = 2'b10,
      CQ_RW   = 2'b11
   } cq_op_e;

   function automatic bit cq_is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

   function automatic int cq_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Count must reach DEPTH itself, hence one extra code point
   function automatic int cq_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/cyclic_queue_fifo_ptr.sv
// Wrapping pointer register with increment enable and synchronous clear.
// Wraps naturally modulo 2**PW, which equals DEPTH for power-of-two depths.
module cq_ptr #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] ptr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr_reg <= '0;
      else if (clr)
         ptr_reg <= '0;
      else if (inc)
         ptr_reg <= ptr_reg + PW'(1);
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/cyclic_queue_fifo.sv
// Circular FIFO with concurrent read/write, occupancy and almost flags,
// optional overwrite-oldest mode and synchronous flush.
module cyclic_queue_fifo
   import cyclic_queue_fifo_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 256,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 2,
   localparam int CW       = cq_cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             ovr,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             rd_en,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic             dropped
);

   localparam int PW = cq_ptr_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   generate
      if (!cq_is_pow2(DEPTH)) begin : g_bad_depth
         $error("cyclic_queue_fifo: DEPTH must be a power of two and >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic [WIDTH-1:0] out_data_reg;
   logic             out_valid_reg;
   logic             dropped_reg;
   logic             wa;
   logic             ra;
   logic             rd_inc;
   cq_op_e           op;

   // Flags come straight from the registered count
   assign empty        = (count_reg == '0);
   assign full         = (count_reg == DEPTH_C);
   assign almost_empty = (count_reg <= AE_C);
   assign almost_full  = (count_reg >= AF_C);
   assign in_ready     = !full | ovr;

   assign wa = in_valid & in_ready & !flush;
   assign ra = rd_en & !empty & !flush;
   assign op = cq_op_e'({ra, wa});

   // A write into a full queue without a read evicts the oldest entry
   assign rd_inc = ra | (wa & full);

   cq_ptr #(.PW(PW)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (wa),
      .ptr (wr_ptr)
   );

   cq_ptr #(.PW(PW)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (rd_inc),
      .ptr (rd_ptr)
   );

   always_comb begin
      count_next = count_reg;
      if (flush) begin
         count_next = '0;
      end else begin
         case (op)
            CQ_WR:   if (!full) count_next = count_reg + CW'(1);
            CQ_RD:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         dropped_reg   <= 1'b0;
      end else begin
         count_reg     <= count_next;
         out_valid_reg <= ra;
         dropped_reg   <= wa & full & !ra;
      end
   end

   // Storage is not reset so it can map onto block RAM
   always_ff @(posedge clk) begin
      if (wa)
         mem[wr_ptr] <= in_data;
   end

   // Read sees the pre-write contents when full with read and write together
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out_data_reg <= '0;
      else if (ra)
         out_data_reg <= mem[rd_ptr];
   end

   assign count     = count_reg;
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign dropped   = dropped_reg;

endmodule

// File: tb/tb_cyclic_queue_fifo.sv
// Scoreboard bench for cyclic_queue_fifo: a queue-based reference model feeds
// expected read words to a monitor that checks whenever out_valid is high.
module tb_cyclic_queue_fifo;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          ovr = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          rd_en = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic [CW-1:0] count;
   logic          empty, full, almost_empty, almost_full, dropped;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] mq[$];     // reference queue contents
   logic [W-1:0] exp_q[$];  // words the DUT must present, in order
   bit           exp_drop;
   logic [W-1:0] last_out = '0;

   always #5 clk = ~clk;

   cyclic_queue_fifo #(
      .WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .ovr(ovr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .rd_en(rd_en), .out_data(out_data), .out_valid(out_valid),
      .count(count), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full),
      .dropped(dropped)
   );

   task automatic check(input string name, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: pops an expected word whenever the DUT presents one
   always @(negedge clk) begin
      if (rst) begin
         last_out = '0;
      end else if (out_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL out_valid: got data %0h expected no read", out_data);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_bad++;
               $display("FAIL out_data: got %0h expected %0h at %0t", out_data, e, $time);
            end
         end
         last_out = out_data;
      end else begin
         check("out_data_hold", int'(out_data), int'(last_out));
      end
   end

   function automatic void model_step(input bit fl, input bit ov, input bit iv,
                                      input logic [W-1:0] d, input bit rd);
      int  sz;
      bit  rdok, wrok;
      exp_drop = 1'b0;
      if (fl) begin
         mq.delete();
         return;
      end
      sz   = mq.size();
      rdok = rd && (sz > 0);
      wrok = iv && ((sz < D) || ov);
      if (rdok) exp_q.push_back(mq.pop_front());
      if (wrok) begin
         if (mq.size() == D) begin
            void'(mq.pop_front());
            exp_drop = 1'b1;
         end
         mq.push_back(d);
      end
   endfunction

   // One clock of stimulus: drive, check status against the model, advance
   task automatic cyc(input bit fl, input bit ov, input bit iv,
                      input logic [W-1:0] d, input bit rd);
      int sz;
      @(negedge clk);
      flush = fl; ovr = ov; in_valid = iv; in_data = d; rd_en = rd;
      #1;
      sz = mq.size();
      check("count", int'(count), sz);
      check("empty", int'(empty), int'(sz == 0));
      check("full", int'(full), int'(sz == D));
      check("almost_empty", int'(almost_empty), int'(sz <= 1));
      check("almost_full", int'(almost_full), int'(sz >= 3));
      check("in_ready", int'(in_ready), int'((sz < D) || ov));
      model_step(fl, ov, iv, d, rd);
      $display("cyc fl=%0d ovr=%0d wr=%0d d=%02h rd=%0d count_before=%0d",
               fl, ov, iv, d, rd, sz);
      @(posedge clk);
      #1;
      check("dropped", int'(dropped), int'(exp_drop));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0);
   endtask

   task automatic check_reset_values();
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_count", int'(count), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_full", int'(full), 0);
      check("rst_almost_empty", int'(almost_empty), 1);
      check("rst_almost_full", int'(almost_full), 0);
      check("rst_dropped", int'(dropped), 0);
      check("rst_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      logic [7:0] fill [4];
      fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

      repeat (2) @(posedge clk);
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;

      // Fill, refused write when full, drain in order
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, fill[i], 0);
      cyc(0, 0, 1, 8'h99, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1);
      idle(1);

      // Overwrite oldest
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, fill[i], 0);
      cyc(0, 1, 1, 8'h55, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00, 1);
      idle(1);

      // Sustained write+read at count 2
      cyc(0, 0, 1, 8'h01, 0);
      cyc(0, 0, 1, 8'h02, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'hA0 + 8'(i), 1);
      cyc(0, 0, 0, 8'h00, 1);
      cyc(0, 0, 0, 8'h00, 1);

      // Full with ovr: concurrent read and write, no drop
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 8'hC0 + 8'(i), 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, 8'hD0 + 8'(i), 1);
      idle(1);
      cyc(0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1);

      // Empty: write with simultaneous read, read ignored
      cyc(0, 0, 1, 8'h7E, 1);
      cyc(0, 0, 0, 8'h00, 1);
      cyc(0, 0, 0, 8'h00, 1);

      // Flush beats write and read
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h60 + 8'(i), 0);
      cyc(1, 0, 1, 8'h6F, 1);
      cyc(0, 0, 1, 8'h3C, 0);
      cyc(0, 0, 0, 8'h00, 1);
      idle(1);

      // Asynchronous reset with count 3 and a read in flight
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h80 + 8'(i), 0);
      cyc(0, 0, 0, 8'h00, 1);
      rst = 1'b1;
      #1;
      mq.delete();
      exp_q.delete();
      check_reset_values();
      @(negedge clk);
      #1;
      check_reset_values();
      rst = 1'b0;
      idle(1);
      cyc(0, 0, 1, 8'h5A, 0);
      cyc(0, 0, 0, 8'h00, 1);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         bit fl, ov, iv, rd;
         fl = ($urandom_range(0, 31) == 0);
         ov = $urandom_range(0, 1);
         iv = ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 2) != 0);
         cyc(fl, ov, iv, 8'($urandom_range(0, 255)), rd);
      end
      idle(3);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
